// File: rtl/calc_mp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// calc_mp_pkg : shared types and helpers for calc_multiport_core
// Rev 1.0
// ------------------------------------------------------------------
package calc_mp_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_ERR  = 2'd2,
      RESP_DROP = 2'd3
   } resp_e;

   typedef enum logic {
      CAP_IDLE = 1'b0,
      CAP_OP2  = 1'b1
   } cap_state_e;

   // Width of the shift-amount field taken from op2.
   function automatic int shamt_width(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/calc_mp_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// calc_mp_fifo : single-clock FIFO, power-of-two DEPTH, full/empty flags
// Rev 1.0
// ------------------------------------------------------------------
module calc_mp_fifo
   import calc_mp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_wr    = i_push & ~o_full;
   assign w_rd    = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/calc_multiport_core.sv
`default_nettype none
// ------------------------------------------------------------------
// calc_multiport_core : N-port tagged calculator sharing one ALU.
// Define CALC_STRICT_PRIO_EN for fixed lowest-port-wins arbitration.
// Rev 1.0
// ------------------------------------------------------------------
module calc_multiport_core
   import calc_mp_pkg::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int CMD_WIDTH   = 4,
   parameter int TAG_WIDTH   = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS*CMD_WIDTH-1:0]  cmd_in,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_PORTS*TAG_WIDTH-1:0]  tag_in,
   output logic [NUM_PORTS*TAG_WIDTH-1:0]  resp_out,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
   output logic [NUM_PORTS*TAG_WIDTH-1:0]  tag_out
);

   localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int SHW = shamt_width(DATA_WIDTH);

   typedef struct packed {
      logic [CMD_WIDTH-1:0]  cmd;
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] op1;
      logic [DATA_WIDTH-1:0] op2;
   } entry_t;

   localparam int EW = $bits(entry_t);

   cap_state_e            r_state     [NUM_PORTS];
   cap_state_e            w_state_nxt [NUM_PORTS];
   logic [CMD_WIDTH-1:0]  r_cmd       [NUM_PORTS];
   logic [TAG_WIDTH-1:0]  r_tag       [NUM_PORTS];
   logic [DATA_WIDTH-1:0] r_op1       [NUM_PORTS];
   logic [EW-1:0]         w_rdata     [NUM_PORTS];
   logic [NUM_PORTS-1:0]  w_full;
   logic [NUM_PORTS-1:0]  w_empty;
   logic [NUM_PORTS-1:0]  w_push;
   logic [NUM_PORTS-1:0]  w_drop;
   logic [NUM_PORTS-1:0]  w_pop;

   logic                  w_win_vld;
   logic [PW-1:0]         w_win;
   logic                  w_stall;
`ifndef CALC_STRICT_PRIO_EN
   logic [PW-1:0]         r_ptr;
`endif

   logic                  r_a_vld;
   logic [PW-1:0]         r_a_port;
   entry_t                r_a;
   logic [DATA_WIDTH:0]   w_sum;
   logic [TAG_WIDTH-1:0]  w_alu_resp;
   logic [DATA_WIDTH-1:0] w_alu_data;

   logic [TAG_WIDTH-1:0]  r_resp  [NUM_PORTS];
   logic [DATA_WIDTH-1:0] r_data  [NUM_PORTS];
   logic [TAG_WIDTH-1:0]  r_tag_o [NUM_PORTS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PORTS; p++) r_state[p] <= CAP_IDLE;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) r_state[p] <= w_state_nxt[p];
      end
   end

   // The push in OP2 becomes a drop when the queue is already full.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_state_nxt[p] = r_state[p];
         w_push[p]      = 1'b0;
         w_drop[p]      = 1'b0;
         case (r_state[p])
            CAP_IDLE: begin
               if (cmd_in[p*CMD_WIDTH +: CMD_WIDTH] != '0) w_state_nxt[p] = CAP_OP2;
            end
            CAP_OP2: begin
               w_state_nxt[p] = CAP_IDLE;
               w_push[p]      = ~w_full[p];
               w_drop[p]      = w_full[p];
            end
            default: w_state_nxt[p] = CAP_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_cmd[p] <= '0;
            r_tag[p] <= '0;
            r_op1[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_state[p] == CAP_IDLE && cmd_in[p*CMD_WIDTH +: CMD_WIDTH] != '0) begin
               r_cmd[p] <= cmd_in[p*CMD_WIDTH +: CMD_WIDTH];
               r_tag[p] <= tag_in[p*TAG_WIDTH +: TAG_WIDTH];
               r_op1[p] <= data_in[p*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   generate
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
         calc_mp_fifo #(
            .WIDTH (EW),
            .DEPTH (QUEUE_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst     (reset),
            .i_push  (w_push[p]),
            .i_data  ({r_cmd[p], r_tag[p], r_op1[p], data_in[p*DATA_WIDTH +: DATA_WIDTH]}),
            .i_pop   (w_pop[p]),
            .o_data  (w_rdata[p]),
            .o_full  (w_full[p]),
            .o_empty (w_empty[p])
         );

         assign resp_out[p*TAG_WIDTH +: TAG_WIDTH]   = r_resp[p];
         assign data_out[p*DATA_WIDTH +: DATA_WIDTH] = r_data[p];
         assign tag_out[p*TAG_WIDTH +: TAG_WIDTH]    = r_tag_o[p];
      end
   endgenerate

   // A drop on the port the ALU is about to answer holds the ALU for one cycle.
   always_comb begin : p_arb
`ifndef CALC_STRICT_PRIO_EN
      logic [PW:0] v_sum;
`endif
      w_win_vld = 1'b0;
      w_win     = '0;
`ifdef CALC_STRICT_PRIO_EN
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (!w_empty[i]) begin
            w_win_vld = 1'b1;
            w_win     = PW'(i);
         end
      end
`else
      v_sum = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         v_sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (v_sum >= (PW+1)'(NUM_PORTS)) v_sum = v_sum - (PW+1)'(NUM_PORTS);
         if (!w_empty[v_sum[PW-1:0]]) begin
            w_win_vld = 1'b1;
            w_win     = v_sum[PW-1:0];
         end
      end
`endif
      w_stall = r_a_vld & w_drop[r_a_port];
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_pop[p] = w_win_vld & ~w_stall & (w_win == PW'(p));
      end
   end

`ifndef CALC_STRICT_PRIO_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_win_vld && !w_stall) begin
         r_ptr <= (w_win == PW'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_vld  <= 1'b0;
         r_a_port <= '0;
         r_a      <= '0;
      end else if (!w_stall) begin
         r_a_vld <= w_win_vld;
         if (w_win_vld) begin
            r_a_port <= w_win;
            r_a      <= entry_t'(w_rdata[w_win]);
         end
      end
   end

   always_comb begin
      w_sum      = {1'b0, r_a.op1} + {1'b0, r_a.op2};
      w_alu_resp = TAG_WIDTH'(RESP_ERR);
      w_alu_data = '0;
      case (r_a.cmd)
         CMD_WIDTH'(CMD_ADD): begin
            if (!w_sum[DATA_WIDTH]) begin
               w_alu_resp = TAG_WIDTH'(RESP_OK);
               w_alu_data = w_sum[DATA_WIDTH-1:0];
            end
         end
         CMD_WIDTH'(CMD_SUB): begin
            if (r_a.op2 <= r_a.op1) begin
               w_alu_resp = TAG_WIDTH'(RESP_OK);
               w_alu_data = r_a.op1 - r_a.op2;
            end
         end
         CMD_WIDTH'(CMD_SHL): begin
            w_alu_resp = TAG_WIDTH'(RESP_OK);
            w_alu_data = r_a.op1 << r_a.op2[SHW-1:0];
         end
         CMD_WIDTH'(CMD_SHR): begin
            w_alu_resp = TAG_WIDTH'(RESP_OK);
            w_alu_data = r_a.op1 >> r_a.op2[SHW-1:0];
         end
         default: begin
            w_alu_resp = TAG_WIDTH'(RESP_ERR);
            w_alu_data = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_resp[p]  <= '0;
            r_data[p]  <= '0;
            r_tag_o[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_resp[p]  <= '0;
            r_data[p]  <= '0;
            r_tag_o[p] <= '0;
            if (w_drop[p]) begin
               r_resp[p]  <= TAG_WIDTH'(RESP_DROP);
               r_tag_o[p] <= r_tag[p];
            end else if (r_a_vld && r_a_port == PW'(p)) begin
               r_resp[p]  <= w_alu_resp;
               r_data[p]  <= w_alu_data;
               r_tag_o[p] <= r_a.tag;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_multiport_core.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_calc_multiport_core : directed + random checks against a queue model
// Rev 1.0
// ------------------------------------------------------------------
module tb_calc_multiport_core;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int CW = 4;
   localparam int TW = 2;
   localparam int QD = 4;

   typedef struct packed {
      logic [CW-1:0] cmd;
      logic [TW-1:0] tag;
      logic [DW-1:0] op1;
      logic [DW-1:0] op2;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NP*CW-1:0] cmd_in;
   logic [NP*DW-1:0] data_in;
   logic [NP*TW-1:0] tag_in;
   logic [NP*TW-1:0] resp_out;
   logic [NP*DW-1:0] data_out;
   logic [NP*TW-1:0] tag_out;

   logic [CW-1:0] b_cmd  [NP];
   logic [DW-1:0] b_data [NP];
   logic [TW-1:0] b_tag  [NP];

   int checks = 0;
   int errors = 0;
   int drops_seen = 0;

   calc_multiport_core #(
      .NUM_PORTS   (NP),
      .DATA_WIDTH  (DW),
      .CMD_WIDTH   (CW),
      .TAG_WIDTH   (TW),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_in   (cmd_in),
      .data_in  (data_in),
      .tag_in   (tag_in),
      .resp_out (resp_out),
      .data_out (data_out),
      .tag_out  (tag_out)
   );

   always #5 clk = ~clk;

   always_comb begin
      cmd_in  = '0;
      data_in = '0;
      tag_in  = '0;
      for (int p = 0; p < NP; p++) begin
         cmd_in[p*CW +: CW]  = b_cmd[p];
         data_in[p*DW +: DW] = b_data[p];
         tag_in[p*TW +: TW]  = b_tag[p];
      end
   end

   // ---------------- behavioural model ----------------
   ent_t          mq    [NP][$];
   int            m_st  [NP];
   ent_t          m_cap [NP];
   int            m_ptr   = 0;
   bit            m_avld  = 0;
   int            m_aport = 0;
   ent_t          m_a;
   logic [TW-1:0] e_resp [NP] = '{default: '0};
   logic [DW-1:0] e_data [NP] = '{default: '0};
   logic [TW-1:0] e_tag  [NP] = '{default: '0};

   function automatic void alu(input ent_t e, output logic [TW-1:0] r, output logic [DW-1:0] d);
      longint s;
      r = 2;
      d = 0;
      case (e.cmd)
         4'd1: begin
            s = longint'(e.op1) + longint'(e.op2);
            if (s < 64'h1_0000_0000) begin r = 1; d = e.op1 + e.op2; end
         end
         4'd2: if (e.op2 <= e.op1) begin r = 1; d = e.op1 - e.op2; end
         4'd5: begin r = 1; d = e.op1 << (e.op2 % 32); end
         4'd6: begin r = 1; d = e.op1 >> (e.op2 % 32); end
         default: begin r = 2; d = 0; end
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin : p_model
      bit            drop [NP];
      bit            stall;
      int            w;
      int            c;
      logic [TW-1:0] r;
      logic [DW-1:0] d;
      ent_t          e;
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            m_st[p]   = 0;
            e_resp[p] = 0;
            e_data[p] = 0;
            e_tag[p]  = 0;
         end
         m_ptr  = 0;
         m_avld = 0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            drop[p]   = (m_st[p] == 1) && (mq[p].size() == QD);
            e_resp[p] = 0;
            e_data[p] = 0;
            e_tag[p]  = 0;
         end
         stall = m_avld && drop[m_aport];
         if (m_avld && !stall) begin
            alu(m_a, r, d);
            e_resp[m_aport] = r;
            e_data[m_aport] = d;
            e_tag[m_aport]  = m_a.tag;
         end
         for (int p = 0; p < NP; p++) begin
            if (drop[p]) begin
               e_resp[p] = 3;
               e_data[p] = 0;
               e_tag[p]  = m_cap[p].tag;
               drops_seen++;
            end
         end
         if (!stall) begin
            w = -1;
            for (int k = 0; k < NP; k++) begin
`ifdef CALC_STRICT_PRIO_EN
               c = k;
`else
               c = (m_ptr + k) % NP;
`endif
               if (w < 0 && mq[c].size() > 0) w = c;
            end
            if (w >= 0) begin
               m_a     = mq[w].pop_front();
               m_avld  = 1;
               m_aport = w;
               m_ptr   = (w + 1) % NP;
            end else begin
               m_avld = 0;
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (m_st[p] == 1) begin
               if (!drop[p]) begin
                  e = m_cap[p];
                  e.op2 = b_data[p];
                  mq[p].push_back(e);
               end
               m_st[p] = 0;
            end else if (b_cmd[p] != 0) begin
               m_cap[p] = '{cmd: b_cmd[p], tag: b_tag[p], op1: b_data[p], op2: '0};
               m_st[p]  = 1;
            end
         end
      end
   end

   // ---------------- every-cycle compare ----------------
   always @(negedge clk) begin
      for (int p = 0; p < NP; p++) begin
         checks++;
         if (resp_out[p*TW +: TW] !== e_resp[p] || data_out[p*DW +: DW] !== e_data[p] ||
             tag_out[p*TW +: TW] !== e_tag[p]) begin
            errors++;
            $display("FAIL model_p%0d t=%0t resp/data/tag got %0h/%0h/%0h want %0h/%0h/%0h", p, $time,
                     resp_out[p*TW +: TW], data_out[p*DW +: DW], tag_out[p*TW +: TW],
                     e_resp[p], e_data[p], e_tag[p]);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic issue1(input int p, input logic [CW-1:0] c, input logic [TW-1:0] t,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
      b_cmd[p]  = c;
      b_tag[p]  = t;
      b_data[p] = a;
      @(negedge clk);
      b_cmd[p]  = 0;
      b_data[p] = b;
      @(negedge clk);
      b_data[p] = 0;
   endtask

   task automatic dir(input string nm, input int p, input logic [CW-1:0] c, input logic [TW-1:0] t,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] er, input logic [DW-1:0] ed);
      issue1(p, c, t, a, b);
      repeat (2) @(negedge clk);
      lit({nm, "_resp"}, 64'(resp_out[p*TW +: TW]), 64'(er));
      lit({nm, "_data"}, 64'(data_out[p*DW +: DW]), 64'(ed));
      lit({nm, "_tag"},  64'(tag_out[p*TW +: TW]),  64'(t));
      @(negedge clk);
      lit({nm, "_oneshot"}, 64'(resp_out[p*TW +: TW]), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic burst(input string nm);
      for (int p = 0; p < NP; p++) begin
         b_cmd[p]  = 1;
         b_tag[p]  = TW'(p);
         b_data[p] = DW'(p);
      end
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         b_cmd[p]  = 0;
         b_data[p] = 10;
      end
      @(negedge clk);
      for (int p = 0; p < NP; p++) b_data[p] = 0;
      @(negedge clk);
      for (int k = 0; k < NP; k++) begin
         @(negedge clk);
         lit($sformatf("%s_p%0d_resp", nm, k), 64'(resp_out[k*TW +: TW]), 64'd1);
         lit($sformatf("%s_p%0d_data", nm, k), 64'(data_out[k*DW +: DW]), 64'(k + 10));
      end
   endtask

   function automatic logic [CW-1:0] pick_cmd();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0, 1:    return 4'd1;
         2, 3:    return 4'd2;
         4, 5:    return 4'd5;
         6, 7:    return 4'd6;
         8:       return CW'($urandom_range(3, 4));
         default: return CW'($urandom_range(7, 15));
      endcase
   endfunction

   function automatic logic [DW-1:0] pick_op();
      return ($urandom_range(0, 2) == 0) ? DW'($urandom) : DW'($urandom_range(0, 64));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int ph [NP];
      for (int p = 0; p < NP; p++) begin
         b_cmd[p] = 0; b_data[p] = 0; b_tag[p] = 0; ph[p] = 0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      lit("reset_resp", 64'(resp_out), 64'd0);
      lit("reset_data", 64'(data_out[63:0]), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      dir("add_p0",   0, 4'd1, 2'd2, 32'd5,          32'd7,  2'd1, 32'd12);
      dir("add_ovf",  1, 4'd1, 2'd1, 32'hFFFF_FFFF,  32'd1,  2'd2, 32'd0);
      dir("sub_unf",  1, 4'd2, 2'd3, 32'd3,          32'd4,  2'd2, 32'd0);
      dir("shl_wrap", 1, 4'd5, 2'd0, 32'd1,          32'h21, 2'd1, 32'd2);
      dir("invalid",  1, 4'd9, 2'd2, 32'd8,          32'd8,  2'd2, 32'd0);
      dir("sub_ok",   3, 4'd2, 2'd1, 32'd100,        32'd58, 2'd1, 32'd42);
      dir("shr",      2, 4'd6, 2'd3, 32'h8000_0000,  32'd31, 2'd1, 32'd1);

      do_reset();
      burst("burst1");
      burst("burst2");

      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int p = 0; p < NP; p++) begin
            if (ph[p] != 0) begin
               b_data[p] = pick_op();
               b_cmd[p]  = CW'($urandom);
               b_tag[p]  = TW'($urandom);
               ph[p]     = 0;
            end else if ($urandom_range(0, 99) < 80) begin
               b_cmd[p]  = pick_cmd();
               b_tag[p]  = TW'($urandom);
               b_data[p] = pick_op();
               ph[p]     = 1;
            end else begin
               b_cmd[p]  = 0;
               b_data[p] = DW'($urandom);
            end
         end
         @(negedge clk);
      end
      for (int p = 0; p < NP; p++) begin
         b_cmd[p] = 0; b_data[p] = 0;
      end
      repeat (40) @(negedge clk);
      lit("drops_seen", 64'(drops_seen > 0), 64'd1);

      for (int p = 0; p < 3; p++) begin
         b_cmd[p] = 1; b_tag[p] = TW'(p + 1); b_data[p] = 32'd9;
      end
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
         b_cmd[p] = 0; b_data[p] = 32'd9;
      end
      @(negedge clk);
      for (int p = 0; p < 3; p++) b_data[p] = 0;
      #1 reset = 1'b1;
      #1;
      lit("rst_async_resp", 64'(resp_out), 64'd0);
      lit("rst_async_tag",  64'(tag_out), 64'd0);
      lit("rst_async_data", 64'(data_out[63:0]), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      dir("post_rst_add", 0, 4'd1, 2'd1, 32'd1, 32'd1, 2'd1, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
